// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg
//   Shared widths, constants and types for the instruction fetch stage.
//   INST_W / ADDR_W : instruction and address widths
//   PC_INC          : sequential PC step
//   iq_entry_t      : one IQ entry, {pc, inst} = 64 bits
//   fetch_state_e   : fetch FSM encoding
package inst_fetcher_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } iq_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_inst_queue.sv
// inst_queue
//   In-order instruction FIFO between the fetch FSM and the decoder.
//   clk_in, rst_in    : clock, synchronous active-high reset
//   push_i, entry_i   : write one {pc, inst} entry at the tail
//   pop_i             : retire the head entry
//   flush_i           : empty the queue (wins over push/pop)
//   count_o           : occupancy, 0..DEPTH
//   full_o, empty_o   : occupancy flags
//   head_inst_o/pc_o  : head entry contents (raw; caller qualifies with !empty)
// Callers gate push/pop/flush with the global ready themselves.
module inst_queue
   import inst_fetcher_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        push_i,
   input  iq_entry_t                   entry_i,
   input  logic                        pop_i,
   input  logic                        flush_i,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [INST_W-1:0]           head_inst_o,
   output logic [ADDR_W-1:0]           head_pc_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   iq_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Pointers are power-of-two sized, so increments wrap for free.
         if (push_i) tail_d = tail_q + 1'b1;
         if (pop_i)  head_d = head_q + 1'b1;
         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk_in) begin
      if (push_i && !flush_i && !rst_in) mem_q[tail_q] <= entry_i;
   end

   assign count_o     = count_q;
   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign head_inst_o = mem_q[head_q].inst;
   assign head_pc_o   = mem_q[head_q].pc;

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher
//   Fetch stage: owns the PC, issues one cache request at a time, buffers
//   responses in an in-order IQ and hands them to the decoder.
//   clk_in, rst_in, rdy_in       : clock, sync active-high reset, global ready
//   rob_clear_up, rob_new_pc     : misprediction redirect
//   start_fetch, pc              : request to cache (held until fetch_ready)
//   fetch_ready, inst, inst_addr : cache response strobe and payload
//   dec_valid, dec_ready         : decoder handshake on the IQ head
//   dec_inst, dec_pc             : IQ head, zero when dec_valid is low
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int                IQ_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              rob_clear_up,
   input  logic [ADDR_W-1:0] rob_new_pc,
   output logic              start_fetch,
   output logic [ADDR_W-1:0] pc,
   input  logic              fetch_ready,
   input  logic [INST_W-1:0] inst,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [INST_W-1:0] dec_inst,
   output logic [ADDR_W-1:0] dec_pc
);

   localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic              flush;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  iq_count;
   logic [CNT_W-1:0]  cnt_after;
   logic              iq_full;
   logic              iq_empty;
   logic [INST_W-1:0] head_inst;
   logic [ADDR_W-1:0] head_pc;

   assign flush = rdy_in && rob_clear_up && !rst_in;

   // Only a response matching the outstanding PC is accepted; anything else
   // is a leftover from before a redirect. A response coincident with a
   // flush is dropped along with the rest of the stream.
   assign push = rdy_in && !rob_clear_up && !rst_in && (state_q == ST_REQ)
                 && fetch_ready && (inst_addr == pc_q);

   assign dec_valid = !rst_in && !flush && !iq_empty;
   assign pop       = dec_valid && dec_ready && rdy_in;
   assign dec_inst  = dec_valid ? head_inst : '0;
   assign dec_pc    = dec_valid ? head_pc   : '0;

   assign start_fetch = !rst_in && !flush && (state_q == ST_REQ) && !iq_full;
   assign pc          = pc_q;

   // Occupancy after this cycle's push/pop; drives the REQ/IDLE decision so a
   // pop lets the request go out on the very next cycle.
   assign cnt_after = iq_count + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (flush) begin
         state_d = ST_REQ;
         pc_d    = rob_new_pc;
      end else if (rdy_in) begin
         case (state_q)
            ST_REQ: begin
               if (push) begin
                  pc_d    = pc_q + PC_INC;
                  state_d = (cnt_after < CNT_W'(IQ_DEPTH)) ? ST_REQ : ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (cnt_after < CNT_W'(IQ_DEPTH)) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
      end else if (rdy_in) begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   inst_queue #(
      .DEPTH(IQ_DEPTH)
   ) u_iq (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .push_i      (push),
      .entry_i     ('{pc: inst_addr, inst: inst}),
      .pop_i       (pop),
      .flush_i     (flush),
      .count_o     (iq_count),
      .full_o      (iq_full),
      .empty_o     (iq_empty),
      .head_inst_o (head_inst),
      .head_pc_o   (head_pc)
   );

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

   localparam int DEPTH = 4;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_clear_up, fetch_ready, dec_ready;
   logic [31:0] rob_new_pc, inst, inst_addr;
   logic        start_fetch, dec_valid;
   logic [31:0] pc, dec_inst, dec_pc;

   inst_fetcher #(.IQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rob_clear_up(rob_clear_up), .rob_new_pc(rob_new_pc),
      .start_fetch(start_fetch), .pc(pc),
      .fetch_ready(fetch_ready), .inst(inst), .inst_addr(inst_addr),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_inst(dec_inst), .dec_pc(dec_pc)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rst, rdy, clr;
      logic [31:0] npc;
      logic        fr;
      logic [31:0] ins, addr;
      logic        dr;
      logic        sf;
      logic [31:0] pc;
      logic        dv;
      logic [31:0] di, dp;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: PC plus an ordered list of buffered {pc, inst}.
   // The fetcher requests exactly when the buffer has room.
   logic [31:0] m_pc;
   logic [31:0] m_qpc[$];
   logic [31:0] m_qinst[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic rst, logic rdy, logic clr, logic [31:0] npc,
                               logic fr, logic [31:0] ins, logic [31:0] addr, logic dr,
                               logic sf, logic [31:0] epc, logic dv,
                               logic [31:0] di, logic [31:0] dp);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.clr = clr; v.npc = npc; v.fr = fr;
      v.ins = ins; v.addr = addr; v.dr = dr; v.sf = sf; v.pc = epc;
      v.dv = dv; v.di = di; v.dp = dp;
      return v;
   endfunction

   task automatic step(input vec_t v, input bit use_tbl, input int idx);
      logic        e_sf, e_dv, flush, pop, push;
      logic [31:0] e_di, e_dp;
      @(negedge clk_in);
      rst_in = v.rst; rdy_in = v.rdy; rob_clear_up = v.clr; rob_new_pc = v.npc;
      fetch_ready = v.fr; inst = v.ins; inst_addr = v.addr; dec_ready = v.dr;
      #1;
      flush = v.rdy && v.clr;
      e_sf  = !v.rst && !flush && (m_qpc.size() < DEPTH);
      e_dv  = !v.rst && !flush && (m_qpc.size() > 0);
      e_di  = e_dv ? m_qinst[0] : 32'h0;
      e_dp  = e_dv ? m_qpc[0]   : 32'h0;
      chk("start_fetch", {31'b0, start_fetch}, {31'b0, e_sf});
      chk("pc",          pc,                   m_pc);
      chk("dec_valid",   {31'b0, dec_valid},   {31'b0, e_dv});
      chk("dec_inst",    dec_inst,             e_di);
      chk("dec_pc",      dec_pc,               e_dp);
      if (use_tbl) begin
         chk($sformatf("row%0d_sf", idx), {31'b0, start_fetch}, {31'b0, v.sf});
         chk($sformatf("row%0d_pc", idx), pc,                   v.pc);
         chk($sformatf("row%0d_dv", idx), {31'b0, dec_valid},   {31'b0, v.dv});
         chk($sformatf("row%0d_di", idx), dec_inst,             v.di);
         chk($sformatf("row%0d_dp", idx), dec_pc,               v.dp);
      end
      @(posedge clk_in);
      if (v.rst) begin
         m_pc = 32'h0; m_qpc.delete(); m_qinst.delete();
      end else if (v.rdy) begin
         if (v.clr) begin
            m_pc = v.npc; m_qpc.delete(); m_qinst.delete();
         end else begin
            pop  = (m_qpc.size() > 0) && v.dr;
            push = (m_qpc.size() < DEPTH) && v.fr && (v.addr == m_pc);
            if (pop) begin
               void'(m_qpc.pop_front());
               void'(m_qinst.pop_front());
            end
            if (push) begin
               m_qpc.push_back(v.addr);
               m_qinst.push_back(v.ins);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   initial begin
      vec_t v;
      rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; rob_new_pc = '0;
      fetch_ready = 1'b0; inst = '0; inst_addr = '0; dec_ready = 1'b0;
      repeat (2) @(posedge clk_in);
      m_pc = 32'h0;

      //            rst rdy clr npc           fr ins          addr          dr  sf pc            dv di           dp
      tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  0, 32'h0,        0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h0,        0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h13,      32'h0,        0,  1, 32'h0,        0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h4,        1, 32'h13,      32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h104,     32'h4,        0,  1, 32'h4,        1, 32'h13,      32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h108,     32'h8,        0,  1, 32'h8,        1, 32'h13,      32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10C,     32'hC,        0,  1, 32'hC,        1, 32'h13,      32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  0, 32'h10,       1, 32'h13,      32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        1,  0, 32'h10,       1, 32'h13,      32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h10,       1, 32'h104,     32'h4));
      // flush with 3 queued and a response arriving in the same cycle
      tbl.push_back(mk(0, 1, 1, 32'h1000,     1, 32'h110,     32'h10,       1,  0, 32'h10,       0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        1,  1, 32'h1000,     0, 32'h0,       32'h0));
      // stale response
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'hDEAD,    32'h8,        1,  1, 32'h1000,     0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        1,  1, 32'h1000,     0, 32'h0,       32'h0));
      // push into empty IQ with dec_ready high: no same-cycle pop
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2000,    32'h1000,     1,  1, 32'h1000,     0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h1004,     1, 32'h2000,    32'h1000));
      // rdy_in low for 5 cycles with response and dec_ready high
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 0, 0, 32'h0,     1, 32'h3000,    32'h1004,     1,  1, 32'h1004,     1, 32'h2000,    32'h1000));
      // resume: simultaneous push and pop
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h3000,    32'h1004,     1,  1, 32'h1004,     1, 32'h2000,    32'h1000));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h1008,     1, 32'h3000,    32'h1004));
      // reset mid-request
      tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h4000,    32'h1008,     0,  0, 32'h1008,     0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h0,        0, 32'h0,       32'h0));
      // PC wrap
      tbl.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,       32'h0,        0,  0, 32'h0,        0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h55,      32'hFFFFFFFC, 0,  1, 32'hFFFFFFFC, 0, 32'h0,       32'h0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h0,        1, 32'h55,      32'hFFFFFFFC));
      // rob_clear_up ignored while rdy_in low
      tbl.push_back(mk(0, 0, 1, 32'h4444,     0, 32'h0,       32'h0,        0,  1, 32'h0,        1, 32'h55,      32'hFFFFFFFC));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        1,  1, 32'h0,        1, 32'h55,      32'hFFFFFFFC));
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0,  1, 32'h0,        0, 32'h0,       32'h0));

      foreach (tbl[i]) step(tbl[i], 1'b1, i);

      // Randomized traffic against the model; the cache answers only while
      // the model says a request is open, sometimes with a stale address.
      for (int n = 0; n < 3000; n++) begin
         v = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         v.rst  = ($urandom_range(0, 499) == 0);
         v.rdy  = ($urandom_range(0, 7) != 0);
         v.clr  = ($urandom_range(0, 39) == 0);
         v.npc  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFFFFFC);
         v.fr   = (m_qpc.size() < DEPTH) && ($urandom_range(0, 1) == 1);
         v.ins  = $urandom;
         v.addr = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFFFFFC) : m_pc;
         v.dr   = ($urandom_range(0, 2) != 0);
         step(v, 1'b0, n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
